// File: rtl/pxs_frame_events_pkg.sv
// Shared types for the frame event detector: tracker states, coordinate pair
// and the raster-order successor function.
`include "Pxs.vh"

package pxs_frame_events_pkg;

  localparam int CW = 10;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } trk_state_e;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } coord_t;

  // Raster successor: step right, wrap to the next line, wrap to origin after the last pixel.
  function automatic coord_t next_coord(input coord_t c, input logic [CW-1:0] last_x,
                                        input logic [CW-1:0] last_y);
    coord_t n;
    n = c;
    if (c.x == last_x) begin
      n.x = '0;
      n.y = (c.y == last_y) ? '0 : c.y + CW'(1);
    end else begin
      n.x = c.x + CW'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/Pxs.vh
// Pixel stream layout shared by every block that parses RGBStr: raster
// geometry defaults and the coordinate field positions inside the 26-bit word.
`ifndef PXS_VH
`define PXS_VH
`define PXS_COLS 640
`define PXS_ROWS 480
`define PXS_W    26
`define PXS_XC   25:16
`define PXS_YC   15:6
`define PXS_RGB  5:0
`endif

// File: rtl/pxs_coord_tracker.sv
// Follows the raster order of visible pixels: locks on an origin pixel, then
// compares each visible pixel against the expected successor coordinate.
`include "Pxs.vh"

module pxs_coord_tracker
  import pxs_frame_events_pkg::*;
#(
  parameter int COLS = `PXS_COLS,
  parameter int ROWS = `PXS_ROWS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          vis,
  input  logic [CW-1:0] xc,
  input  logic [CW-1:0] yc,
  output trk_state_e    state,
  output logic          mismatch,
  output logic          in_seq
);

  localparam logic [CW-1:0] LAST_X = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_Y = CW'(ROWS - 1);

  trk_state_e state_q;
  trk_state_e state_d;
  coord_t     exp_q;
  coord_t     exp_d;
  coord_t     cur;
  logic       is_origin;

  assign cur.x     = xc;
  assign cur.y     = yc;
  assign is_origin = (xc == '0) && (yc == '0);
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    mismatch = 1'b0;
    in_seq   = 1'b0;
    if (vis) begin
      mismatch = (state_q == RUN) && (cur != exp_q);
      // An origin pixel always (re)locks, even when it is the one that broke the sequence.
      in_seq   = is_origin || ((state_q == RUN) && !mismatch);
      if (in_seq) begin
        state_d = RUN;
        exp_d   = next_coord(cur, LAST_X, LAST_Y);
      end else begin
        state_d = SYNC;
      end
    end
    if (clr) begin
      state_d = SYNC;
    end
  end

endmodule

// File: rtl/pxs_frame_events.sv
// Decodes frame/line events from a pixel stream, counts lines and clean
// frames, and flags coordinate sequence errors; all outputs registered.
`include "Pxs.vh"

module pxs_frame_events
  import pxs_frame_events_pkg::*;
#(
  parameter int COLS = `PXS_COLS,
  parameter int ROWS = `PXS_ROWS,
  parameter int FCW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  input  logic           clr,
  input  logic [25:0]    RGBStr_i,
  output logic [25:0]    RGBStr_o,
  output logic           sof_o,
  output logic           eol_o,
  output logic           eof_o,
  output logic [9:0]     line_cnt_o,
  output logic [FCW-1:0] frame_cnt_o,
  output logic           seq_err_o,
  output logic           frame_ok_o
);

  localparam logic [CW-1:0] LAST_X = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_Y = CW'(ROWS - 1);

  logic [CW-1:0]  xc;
  logic [CW-1:0]  yc;
  logic           vis;
  logic           at_sof;
  logic           at_eol;
  logic           at_eof;
  logic           good_eof;
  logic           mismatch;
  logic           in_seq;
  trk_state_e     trk_state;
  logic [9:0]     line_d;
  logic [FCW-1:0] frame_d;
  logic           ok_d;

  assign xc  = RGBStr_i[`PXS_XC];
  assign yc  = RGBStr_i[`PXS_YC];
  assign vis = pix_en && (xc <= LAST_X) && (yc <= LAST_Y);

  assign at_sof   = vis && (xc == '0) && (yc == '0);
  assign at_eol   = vis && (xc == LAST_X);
  assign at_eof   = at_eol && (yc == LAST_Y);
  assign good_eof = at_eof && (trk_state == RUN) && !mismatch;

  pxs_coord_tracker #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .vis      (vis),
    .xc       (xc),
    .yc       (yc),
    .state    (trk_state),
    .mismatch (mismatch),
    .in_seq   (in_seq)
  );

  // Ordering matters when one pixel carries several events (COLS=1 or ROWS=1 rasters).
  always_comb begin
    line_d = line_cnt_o;
    if (at_sof) begin
      line_d = '0;
    end
    if (at_eol && in_seq && (line_d != LAST_Y)) begin
      line_d = line_d + 10'd1;
    end
    if (at_eof || clr) begin
      line_d = '0;
    end
  end

  always_comb begin
    frame_d = frame_cnt_o;
    ok_d    = frame_ok_o;
    if (clr) begin
      frame_d = '0;
      ok_d    = 1'b0;
    end else if (mismatch) begin
      ok_d    = 1'b0;
    end else if (good_eof) begin
      frame_d = frame_cnt_o + FCW'(1);
      ok_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RGBStr_o    <= '0;
      sof_o       <= 1'b0;
      eol_o       <= 1'b0;
      eof_o       <= 1'b0;
      seq_err_o   <= 1'b0;
      line_cnt_o  <= '0;
      frame_cnt_o <= '0;
      frame_ok_o  <= 1'b0;
    end else begin
      RGBStr_o    <= RGBStr_i;
      sof_o       <= at_sof;
      eol_o       <= at_eol;
      eof_o       <= at_eof;
      seq_err_o   <= mismatch;
      line_cnt_o  <= line_d;
      frame_cnt_o <= frame_d;
      frame_ok_o  <= ok_d;
    end
  end

endmodule

// File: tb/tb_pxs_frame_events.sv
// Directed bench for the frame event detector on a 4x3 raster with a 4-bit
// frame counter; expected values are hand-derived constants.
module tb_pxs_frame_events;

  logic        clk;
  logic        rst_n;
  logic        pix_en;
  logic        clr;
  logic [25:0] RGBStr_i;
  logic [25:0] RGBStr_o;
  logic        sof_o;
  logic        eol_o;
  logic        eof_o;
  logic [9:0]  line_cnt_o;
  logic [3:0]  frame_cnt_o;
  logic        seq_err_o;
  logic        frame_ok_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_sof = 0;
  int n_eol = 0;
  int n_eof = 0;
  int n_err = 0;
  logic [25:0] exp_rgb;

  pxs_frame_events #(
    .COLS (4),
    .ROWS (3),
    .FCW  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .clr         (clr),
    .RGBStr_i    (RGBStr_i),
    .RGBStr_o    (RGBStr_o),
    .sof_o       (sof_o),
    .eol_o       (eol_o),
    .eof_o       (eof_o),
    .line_cnt_o  (line_cnt_o),
    .frame_cnt_o (frame_cnt_o),
    .seq_err_o   (seq_err_o),
    .frame_ok_o  (frame_ok_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_counts();
    n_sof = 0;
    n_eol = 0;
    n_eof = 0;
    n_err = 0;
  endtask

  // Drive one stream word, clock it in, then sample the registered outputs.
  task automatic px(input int x, input int y, input bit en = 1'b1, input bit c = 1'b0);
    logic [5:0] p;
    p        = 6'(x * 7 + y * 3 + 1);
    RGBStr_i = {x[9:0], y[9:0], p};
    pix_en   = en;
    clr      = c;
    exp_rgb  = RGBStr_i;
    @(posedge clk);
    #1;
    clr    = 1'b0;
    n_sof += int'(sof_o);
    n_eol += int'(eol_o);
    n_eof += int'(eof_o);
    n_err += int'(seq_err_o);
    chk("rgb_delay", RGBStr_o, exp_rgb);
  endtask

  task automatic frame(input bit clr_eof = 1'b0);
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        px(x, y, 1'b1, clr_eof && (x == 3) && (y == 2));
      end
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    pix_en   = 1'b0;
    clr      = 1'b0;
    RGBStr_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rgb", RGBStr_o, 0);
    chk("rst_sof", sof_o, 0);
    chk("rst_eol", eol_o, 0);
    chk("rst_eof", eof_o, 0);
    chk("rst_err", seq_err_o, 0);
    chk("rst_line", line_cnt_o, 0);
    chk("rst_frame", frame_cnt_o, 0);
    chk("rst_ok", frame_ok_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean frame 1 with per-pixel event checks
    reset_counts();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        px(x, y);
        if (x == 0 && y == 0) chk("f1_sof_at_origin", sof_o, 1);
        if (x == 1) chk("f1_no_eol_mid", eol_o, 0);
        if (x == 3) chk("f1_line_cnt", line_cnt_o, (y == 2) ? 0 : y + 1);
        if (x == 3 && y == 2) chk("f1_eof_with_eol", {eof_o, eol_o}, 2'b11);
      end
    end
    chk("f1_sof_n", n_sof, 1);
    chk("f1_eol_n", n_eol, 3);
    chk("f1_eof_n", n_eof, 1);
    chk("f1_err_n", n_err, 0);
    chk("f1_frame_cnt", frame_cnt_o, 1);
    chk("f1_frame_ok", frame_ok_o, 1);
    px(5, 0);
    chk("blank_no_eol", eol_o, 0);
    px(0, 4);
    chk("blank_no_sof", sof_o, 0);

    // Clean frame 2
    reset_counts();
    frame();
    chk("f2_sof_n", n_sof, 1);
    chk("f2_eol_n", n_eol, 3);
    chk("f2_eof_n", n_eof, 1);
    chk("f2_err_n", n_err, 0);
    chk("f2_frame_cnt", frame_cnt_o, 2);
    chk("f2_frame_ok", frame_ok_o, 1);

    // Pixel (2,1) replaced by (3,1)
    reset_counts();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        px((x == 2 && y == 1) ? 3 : x, y);
        if (x == 2 && y == 1) chk("err_pulse_now", seq_err_o, 1);
        if (x == 3 && y == 1) chk("err_pulse_once", seq_err_o, 0);
      end
    end
    chk("err_n", n_err, 1);
    chk("err_eof_n", n_eof, 1);
    chk("err_frame_cnt", frame_cnt_o, 2);
    chk("err_frame_ok", frame_ok_o, 0);

    // Recovery with a clean frame
    reset_counts();
    frame();
    chk("rec_err_n", n_err, 0);
    chk("rec_frame_cnt", frame_cnt_o, 3);
    chk("rec_frame_ok", frame_ok_o, 1);

    // pix_en low for 5 cycles mid-line, origin coordinate on the bus
    reset_counts();
    px(0, 0);
    px(1, 0);
    for (int i = 0; i < 5; i++) begin
      px(0, 0, 1'b0);
      chk("hold_sof", sof_o, 0);
      chk("hold_eol", eol_o, 0);
      chk("hold_line", line_cnt_o, 0);
      chk("hold_frame", frame_cnt_o, 3);
      chk("hold_ok", frame_ok_o, 1);
    end
    px(2, 0);
    px(3, 0);
    chk("resume_line", line_cnt_o, 1);
    for (int y = 1; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        px(x, y);
      end
    end
    chk("hold_sof_n", n_sof, 1);
    chk("hold_err_n", n_err, 0);
    chk("hold_frame_cnt", frame_cnt_o, 4);

    // Synchronous clear, then a stream joining at (2,1)
    px(5, 0, 1'b0, 1'b1);
    chk("clr_frame", frame_cnt_o, 0);
    chk("clr_ok", frame_ok_o, 0);
    chk("clr_line", line_cnt_o, 0);
    reset_counts();
    px(2, 1);
    px(3, 1);
    chk("late_line", line_cnt_o, 0);
    for (int x = 0; x < 4; x++) begin
      px(x, 2);
    end
    chk("late_sof_n", n_sof, 0);
    chk("late_eof_n", n_eof, 1);
    chk("late_err_n", n_err, 0);
    chk("late_frame_cnt", frame_cnt_o, 0);
    chk("late_frame_ok", frame_ok_o, 0);
    frame();
    chk("late_next_frame", frame_cnt_o, 1);

    // Counter wrap
    for (int i = 0; i < 14; i++) frame();
    chk("wrap_15", frame_cnt_o, 15);
    frame();
    chk("wrap_0", frame_cnt_o, 0);
    chk("wrap_ok", frame_ok_o, 1);
    frame();
    chk("wrap_1", frame_cnt_o, 1);

    // clr on the eof cycle
    frame(1'b1);
    chk("clr_eof_pulse", eof_o, 1);
    chk("clr_eof_frame", frame_cnt_o, 0);
    chk("clr_eof_ok", frame_ok_o, 0);
    frame();
    chk("post_clr_frame", frame_cnt_o, 1);

    // Asynchronous reset mid-frame, between clock edges
    for (int x = 0; x < 4; x++) begin
      px(x, 0);
    end
    chk("pre_rst_eol", eol_o, 1);
    chk("pre_rst_line", line_cnt_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", RGBStr_o, 0);
    chk("mid_rst_eol", eol_o, 0);
    chk("mid_rst_line", line_cnt_o, 0);
    chk("mid_rst_frame", frame_cnt_o, 0);
    chk("mid_rst_ok", frame_ok_o, 0);
    #2 rst_n = 1'b1;
    reset_counts();
    for (int y = 1; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        px(x, y);
      end
    end
    chk("partial_err_n", n_err, 0);
    chk("partial_eof_n", n_eof, 1);
    chk("partial_frame", frame_cnt_o, 0);
    frame();
    chk("after_rst_frame", frame_cnt_o, 1);
    chk("after_rst_ok", frame_ok_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
